usb_tx_encoder: RTL
===================

Name: usb_tx_encoder

Overview:
Bit-level USB full-speed transmit stage that sits directly downstream of the USB transmit controller. It captures one byte per load and serializes it LSB-first at the bus bit rate. It applies bit stuffing and NRZI encoding, drives the differential pair, and generates end-of-packet (SE0, SE0, J). It reports per-byte completion (byte_sent) back to the controller.

Parameters:
CLKS_PER_BIT, 4, system clocks per USB bit period (48 MHz clk / 12 Mbps); must be >= 2.
STUFF_LIMIT, 6, consecutive transmitted 1s after which a stuffed 0 is inserted.

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  asynchronous active-low reset.
tx_byte  input  8  byte to transmit; sampled when load_enable=1.
load_enable  input  1  capture tx_byte into shift register (single-cycle strobe).
tx_enable  input  1  permission to shift; held high by controller while a byte is in flight.
create_eop  input  1  request EOP generation (single-cycle strobe).
byte_sent  output  1  one-clock pulse when a byte, including any stuffed bit it caused, has fully left the line.
eop_done  output  1  one-clock pulse when EOP J bit period ends.
tx_busy  output  1  high in any state except IDLE.
d_plus  output  1  USB D+ line.
d_minus  output  1  USB D- line.

Behaviour:
- Reset (async, n_rst=0): state IDLE, d_plus=1, d_minus=0 (J), byte_sent=0, eop_done=0, tx_busy=0. Shift register=0, byte_loaded=0, eop_pending=0, ones count=0, bit timer=0, bit index=0, NRZI level=J. Reset mid-packet aborts immediately to these values.
- Bit timer: counts 0..CLKS_PER_BIT-1 while state != IDLE, then wraps. "Bit boundary" = timer==CLKS_PER_BIT-1. The line changes only on the clock after a bit boundary, or on entry from IDLE. The timer resets to 0 on IDLE exit.
- load_enable: accepted in IDLE or WAIT only. It sets byte_loaded=1 and bit index=0. load_enable in SHIFT/STUFF/EOP states is ignored.
- create_eop: sets eop_pending in any non-EOP state. It is acted on only from IDLE or WAIT. If both byte_loaded and eop_pending are set, the byte is sent first.
- NRZI: a data 0 toggles the line (J<->K); a data 1 holds it. J = (1,0), K = (0,1), SE0 = (0,0).
- Bit stuffing: ones count increments on each transmitted 1 and clears on any transmitted 0, including a stuffed 0. When the count reaches STUFF_LIMIT, the next bit period is a stuffed 0 (STUFF state). The ones count persists across bytes and clears in IDLE and EOP.
- States:
  IDLE: line J. byte_loaded & tx_enable -> SHIFT (bit 0 driven next clock, timer=0). eop_pending -> EOP_SE0_1.
  SHIFT: drive bit[index]. At bit boundary:
    - if ones==STUFF_LIMIT -> STUFF;
    - else if index==7 -> pulse byte_sent, clear byte_loaded, -> WAIT;
    - else index+1.
    - If tx_enable=0 at the bit boundary, the current bit completes and the state then holds (line steady) until tx_enable returns.
  STUFF: drive stuffed 0 for one bit period. At boundary: if index==7 -> byte_sent, -> WAIT; else index+1 -> SHIFT.
  WAIT: hold line level, timer free-running. At bit boundary:
    - byte_loaded & tx_enable -> SHIFT;
    - else eop_pending -> EOP_SE0_1;
    - else stay. No IDLE exit except via EOP.
  EOP_SE0_1 / EOP_SE0_2: SE0 for one bit period each.
  EOP_J: J for one bit period. At boundary: pulse eop_done, clear eop_pending/ones/NRZI level=J, -> IDLE.
- byte_sent and eop_done are never high in the same cycle. Each is high for exactly one clk.
- Byte latency: load in IDLE -> byte_sent after 8*CLKS_PER_BIT clocks (+CLKS_PER_BIT per stuffed bit).

Test Plan:
- Reset, load 0x00, tx_enable=1 -> line K,J,K,J,K,J,K,J, each 4 clks; byte_sent pulses once at clk 32; ends J.
- Load 0xFF -> 6 bit periods J held, stuffed 0 -> K, then 2 periods K; byte_sent at clk 36. Reload 0xFF in WAIT -> stuffed bit after its 4th bit (ones carried=2); byte_sent after 9 periods.
- After byte_sent, pulse create_eop -> at next boundary SE0 for 8 clks, J for 4 clks, eop_done pulse, tx_busy falls, state IDLE.
- Pulse load_enable with 0xAA during SHIFT of 0x0F -> ignored; line reflects 0x0F only, one byte_sent.
- Drop tx_enable mid-byte for 10 clks -> current bit completes, line frozen, shifting resumes with correct remaining bits; no extra byte_sent.
- Assert n_rst during EOP_SE0_1 -> same cycle d_plus=1, d_minus=0, tx_busy=0; new load afterwards transmits normally with ones count 0.

Source files
------------

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit bit stage: captures a byte, serializes it LSB-first
// with bit stuffing and NRZI encoding, drives D+/D-, and generates EOP
// (SE0, SE0, J). Reports per-byte completion and EOP completion as pulses.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 4,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_byte,
    input  logic       load_enable,
    input  logic       tx_enable,
    input  logic       create_eop,
    output logic       byte_sent,
    output logic       eop_done,
    output logic       tx_busy,
    output logic       d_plus,
    output logic       d_minus
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int ONES_W  = $clog2(STUFF_LIMIT + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [ONES_W-1:0]  ONES_MAX  = ONES_W'(STUFF_LIMIT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT     = 3'd1,
        STUFF     = 3'd2,
        WAIT      = 3'd3,
        EOP_SE0_1 = 3'd4,
        EOP_SE0_2 = 3'd5,
        EOP_J     = 3'd6
    } state_t;

    state_t              state;
    logic [TIMER_W-1:0]  timer;
    logic [7:0]          shift_reg;
    logic [2:0]          bit_index;
    logic                byte_loaded;
    logic                eop_pending;
    logic [ONES_W-1:0]   ones;
    logic                nrzi_level;   // 1 = J, 0 = K

    logic                at_boundary;
    logic                in_eop;
    logic                can_load;
    logic                first_bit;
    logic                first_level;
    logic [2:0]          next_index;
    logic                next_bit;
    logic                next_level;
    logic                ones_full;

    assign at_boundary = (timer == TIMER_MAX);
    assign in_eop      = (state == EOP_SE0_1) || (state == EOP_SE0_2) || (state == EOP_J);
    assign can_load    = load_enable && ((state == IDLE) || (state == WAIT));
    // A load landing on the very edge that starts shifting replaces the byte,
    // so bit 0 must come from the incoming byte rather than the stale register.
    assign first_bit   = can_load ? tx_byte[0] : shift_reg[0];
    assign first_level = first_bit ? nrzi_level : ~nrzi_level;
    assign next_index  = bit_index + 3'd1;
    assign next_bit    = shift_reg[next_index];
    assign next_level  = next_bit ? nrzi_level : ~nrzi_level;
    assign ones_full   = (ones == ONES_MAX);

    // Transmit FSM: bit timing, byte capture, stuffing, NRZI line and pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            timer       <= '0;
            shift_reg   <= '0;
            bit_index   <= '0;
            byte_loaded <= 1'b0;
            eop_pending <= 1'b0;
            ones        <= '0;
            nrzi_level  <= 1'b1;
            byte_sent   <= 1'b0;
            eop_done    <= 1'b0;
            tx_busy     <= 1'b0;
            d_plus      <= 1'b1;
            d_minus     <= 1'b0;
        end else begin
            byte_sent <= 1'b0;
            eop_done  <= 1'b0;

            if (state != IDLE) begin
                timer <= at_boundary ? '0 : timer + TIMER_W'(1);
            end

            if (can_load) begin
                shift_reg   <= tx_byte;
                byte_loaded <= 1'b1;
                bit_index   <= 3'd0;
            end

            if (create_eop && !in_eop) begin
                eop_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    timer <= '0;
                    ones  <= '0;
                    if (byte_loaded) begin
                        if (tx_enable) begin
                            state      <= SHIFT;
                            tx_busy    <= 1'b1;
                            ones       <= first_bit ? ONES_W'(1) : '0;
                            nrzi_level <= first_level;
                            d_plus     <= first_level;
                            d_minus    <= ~first_level;
                        end
                    end else if (eop_pending) begin
                        state   <= EOP_SE0_1;
                        tx_busy <= 1'b1;
                        d_plus  <= 1'b0;
                        d_minus <= 1'b0;
                    end
                end

                SHIFT: begin
                    // With tx_enable low the finished bit simply stays on the line.
                    if (at_boundary && tx_enable) begin
                        if (ones_full) begin
                            state      <= STUFF;
                            ones       <= '0;
                            nrzi_level <= ~nrzi_level;
                            d_plus     <= ~nrzi_level;
                            d_minus    <= nrzi_level;
                        end else if (bit_index == 3'd7) begin
                            state       <= WAIT;
                            byte_sent   <= 1'b1;
                            byte_loaded <= 1'b0;
                        end else begin
                            bit_index  <= next_index;
                            ones       <= next_bit ? ones + ONES_W'(1) : '0;
                            nrzi_level <= next_level;
                            d_plus     <= next_level;
                            d_minus    <= ~next_level;
                        end
                    end
                end

                STUFF: begin
                    if (at_boundary) begin
                        if (bit_index == 3'd7) begin
                            state       <= WAIT;
                            byte_sent   <= 1'b1;
                            byte_loaded <= 1'b0;
                        end else begin
                            state      <= SHIFT;
                            bit_index  <= next_index;
                            ones       <= next_bit ? ones + ONES_W'(1) : '0;
                            nrzi_level <= next_level;
                            d_plus     <= next_level;
                            d_minus    <= ~next_level;
                        end
                    end
                end

                WAIT: begin
                    if (at_boundary) begin
                        if (byte_loaded) begin
                            if (tx_enable) begin
                                state      <= SHIFT;
                                ones       <= first_bit ? ones + ONES_W'(1) : '0;
                                nrzi_level <= first_level;
                                d_plus     <= first_level;
                                d_minus    <= ~first_level;
                            end
                        end else if (eop_pending) begin
                            state   <= EOP_SE0_1;
                            ones    <= '0;
                            d_plus  <= 1'b0;
                            d_minus <= 1'b0;
                        end
                    end
                end

                EOP_SE0_1: begin
                    ones <= '0;
                    if (at_boundary) begin
                        state <= EOP_SE0_2;
                    end
                end

                EOP_SE0_2: begin
                    ones <= '0;
                    if (at_boundary) begin
                        state   <= EOP_J;
                        d_plus  <= 1'b1;
                        d_minus <= 1'b0;
                    end
                end

                EOP_J: begin
                    ones <= '0;
                    if (at_boundary) begin
                        state       <= IDLE;
                        tx_busy     <= 1'b0;
                        eop_done    <= 1'b1;
                        eop_pending <= 1'b0;
                        nrzi_level  <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                    d_plus  <= 1'b1;
                    d_minus <= 1'b0;
                end
            endcase
        end
    end

endmodule
